// File: rtl/cr_prefix_load_pmw.sv
// cr_prefix_load_pmw: loads one PFD or PHD prefix image from a 64-bit beat
// stream into the PFD/PHD memories. It also writes the complemented XP10 CRC32
// of the stored words into the CRC table held in PFD memory, so that the
// read-side checker can verify the image later.
module cr_prefix_load_pmw #(
  parameter int N_PFD_WORDS = 128,
  parameter int N_PHD_WORDS = 64,
  parameter int PHD_STRIDE  = 65
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_data,
  input  logic        wr_last,
  input  logic [5:0]  wr_prefix_num,
  input  logic        wr_is_phd,
  output logic        pfd_wr_en,
  output logic [12:0] pfd_wr_addr,
  output logic [63:0] pfd_wr_data,
  output logic        phd_wr_en,
  output logic [11:0] phd_wr_addr,
  output logic [63:0] phd_wr_data,
  output logic        pmw_busy,
  output logic        pmw_done,
  output logic        pmw_err,
  output logic [31:0] pmw_crc
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_DRAIN  = 3'd2,
    S_CRC_WR = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // XP10 CRC32 (reflected 0xEDB88320), data consumed LSB first; identical to
  // the reader-side recompute so both ends agree bit for bit.
  function automatic logic [31:0] crc32_xp(input logic [63:0] data,
                                           input logic [31:0] crc_in,
                                           input int          nbits);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 64; i++) begin
      if (i < nbits) begin
        if (c[0] ^ data[i]) begin
          c = (c >> 1) ^ 32'hEDB8_8320;
        end else begin
          c = c >> 1;
        end
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  prefix_q, prefix_d;
  logic        is_phd_q, is_phd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        pfd_en_q, pfd_en_d;
  logic [12:0] pfd_addr_q, pfd_addr_d;
  logic [63:0] pfd_data_q, pfd_data_d;
  logic        phd_en_q, phd_en_d;
  logic [11:0] phd_addr_q, phd_addr_d;
  logic [63:0] phd_data_q, phd_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] crc_q, crc_d;

  logic        beat_s;
  logic        data_beat_s;
  logic [5:0]  cur_prefix_s;
  logic        cur_phd_s;
  logic [7:0]  cur_k_s;
  logic [7:0]  k_last_s;
  logic [11:0] phd_base_s;
  logic [31:0] crc_next_s;

  // Next-state, write-port and CRC accumulator computation.
  always_comb begin
    state_d    = state_q;
    prefix_d   = prefix_q;
    is_phd_d   = is_phd_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    pfd_en_d   = 1'b0;
    pfd_addr_d = pfd_addr_q;
    pfd_data_d = pfd_data_q;
    phd_en_d   = 1'b0;
    phd_addr_d = phd_addr_q;
    phd_data_d = phd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    crc_d      = crc_q;
    data_beat_s = 1'b0;

    beat_s = wr_valid & ready_q;

    // The first beat's prefix/kind are used directly; later beats use the latch.
    if (state_q == S_IDLE) begin
      cur_prefix_s = wr_prefix_num;
      cur_phd_s    = wr_is_phd;
      cur_k_s      = 8'd0;
    end else begin
      cur_prefix_s = prefix_q;
      cur_phd_s    = is_phd_q;
      cur_k_s      = cnt_q;
    end

    if (cur_phd_s) begin
      k_last_s = 8'(N_PHD_WORDS - 1);
    end else begin
      k_last_s = 8'(N_PFD_WORDS - 1);
    end

    phd_base_s = (12'(cur_prefix_s) - 12'd1) * 12'(PHD_STRIDE);
    crc_next_s = crc32_xp(wr_data, acc_q, 64);

    case (state_q)
      S_IDLE: begin
        if (beat_s) begin
          prefix_d = wr_prefix_num;
          is_phd_d = wr_is_phd;
          if (wr_prefix_num == 6'd0) begin
            err_d = 1'b1;
            acc_d = CRC_INIT;
            cnt_d = 8'd0;
            if (wr_last) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            data_beat_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (beat_s) begin
          data_beat_s = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DRAIN: begin
        if (beat_s && wr_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_CRC_WR: begin
        pfd_en_d   = 1'b1;
        pfd_addr_d = {6'd0, is_phd_q, prefix_q};
        pfd_data_d = {32'd0, ~acc_q};
        crc_d      = ~acc_q;
        done_d     = 1'b1;
        state_d    = S_FIN;
      end
      S_FIN: begin
        acc_d   = CRC_INIT;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: begin
        acc_d   = CRC_INIT;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase

    if (data_beat_s) begin
      if (wr_last && (cur_k_s != k_last_s)) begin
        // Short image: this beat is dropped and the CRC entry is left stale.
        err_d   = 1'b1;
        acc_d   = CRC_INIT;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end else begin
        if (cur_phd_s) begin
          phd_en_d   = 1'b1;
          phd_addr_d = phd_base_s + 12'(cur_k_s);
          phd_data_d = wr_data;
        end else begin
          pfd_en_d   = 1'b1;
          pfd_addr_d = {cur_prefix_s, cur_k_s[6:0]};
          pfd_data_d = wr_data;
        end
        if (cur_k_s == k_last_s) begin
          if (wr_last) begin
            acc_d   = crc_next_s;
            cnt_d   = cur_k_s + 8'd1;
            state_d = S_CRC_WR;
          end else begin
            // Long image: final word kept, surplus beats swallowed in DRAIN.
            err_d   = 1'b1;
            acc_d   = CRC_INIT;
            cnt_d   = 8'd0;
            state_d = S_DRAIN;
          end
        end else begin
          acc_d   = crc_next_s;
          cnt_d   = cur_k_s + 8'd1;
          state_d = S_DATA;
        end
      end
    end else begin
      data_beat_s = 1'b0;
    end

    ready_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_DRAIN);
    busy_d  = (state_d != S_IDLE);
  end

  // State, context and registered outputs; reset aborts any transfer silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prefix_q   <= 6'd0;
      is_phd_q   <= 1'b0;
      cnt_q      <= 8'd0;
      acc_q      <= CRC_INIT;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      pfd_en_q   <= 1'b0;
      pfd_addr_q <= 13'd0;
      pfd_data_q <= 64'd0;
      phd_en_q   <= 1'b0;
      phd_addr_q <= 12'd0;
      phd_data_q <= 64'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      crc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      prefix_q   <= prefix_d;
      is_phd_q   <= is_phd_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      pfd_en_q   <= pfd_en_d;
      pfd_addr_q <= pfd_addr_d;
      pfd_data_q <= pfd_data_d;
      phd_en_q   <= phd_en_d;
      phd_addr_q <= phd_addr_d;
      phd_data_q <= phd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      crc_q      <= crc_d;
    end
  end

  assign wr_ready    = ready_q;
  assign pmw_busy    = busy_q;
  assign pfd_wr_en   = pfd_en_q;
  assign pfd_wr_addr = pfd_addr_q;
  assign pfd_wr_data = pfd_data_q;
  assign phd_wr_en   = phd_en_q;
  assign phd_wr_addr = phd_addr_q;
  assign phd_wr_data = phd_data_q;
  assign pmw_done    = done_q;
  assign pmw_err     = err_q;
  assign pmw_crc     = crc_q;

endmodule

// File: tb/tb_cr_prefix_load_pmw.sv
// Directed bench for cr_prefix_load_pmw: full PFD/PHD loads, short and long
// images, prefix 0 rejection, valid gaps and reset in the middle of a load.
module tb_cr_prefix_load_pmw;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        wr_last;
  logic [5:0]  wr_prefix_num;
  logic        wr_is_phd;
  logic        pfd_wr_en;
  logic [12:0] pfd_wr_addr;
  logic [63:0] pfd_wr_data;
  logic        phd_wr_en;
  logic [11:0] phd_wr_addr;
  logic [63:0] phd_wr_data;
  logic        pmw_busy;
  logic        pmw_done;
  logic        pmw_err;
  logic [31:0] pmw_crc;

  int n_cmp = 0;
  int n_bad = 0;

  cr_prefix_load_pmw #(.N_PFD_WORDS(128), .N_PHD_WORDS(64), .PHD_STRIDE(65)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .wr_prefix_num(wr_prefix_num), .wr_is_phd(wr_is_phd),
    .pfd_wr_en(pfd_wr_en), .pfd_wr_addr(pfd_wr_addr), .pfd_wr_data(pfd_wr_data),
    .phd_wr_en(phd_wr_en), .phd_wr_addr(phd_wr_addr), .phd_wr_data(phd_wr_data),
    .pmw_busy(pmw_busy), .pmw_done(pmw_done), .pmw_err(pmw_err), .pmw_crc(pmw_crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/pulse log captured on the falling edge
  logic [12:0] pfd_a[$];
  logic [63:0] pfd_d[$];
  logic [11:0] phd_a[$];
  logic [63:0] phd_d[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int done_nocrc_cnt = 0;

  always @(negedge clk) begin
    if (pfd_wr_en) begin pfd_a.push_back(pfd_wr_addr); pfd_d.push_back(pfd_wr_data); end
    if (phd_wr_en) begin phd_a.push_back(phd_wr_addr); phd_d.push_back(phd_wr_data); end
    if (pmw_done) done_cnt++;
    if (pmw_err) err_cnt++;
    if (pfd_wr_en && phd_wr_en) both_cnt++;
    if (pmw_done && !(pfd_wr_en && pfd_wr_addr[12:7] == 6'd0)) done_nocrc_cnt++;
  end

  // Reference XP10 CRC32 step: reflected polynomial, data LSB first
  function automatic logic [31:0] ref_crc_word(input logic [31:0] c, input logic [63:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 64; b++) r = (r >> 1) ^ (32'hEDB8_8320 & {32{r[0] ^ w[b]}});
    return r;
  endfunction

  function automatic logic [63:0] pfd_word(input int k, input int seed);
    return {32'(k * seed), 32'(k)};
  endfunction

  task automatic clear_log();
    pfd_a.delete(); pfd_d.delete(); phd_a.delete(); phd_d.delete();
    done_cnt = 0; err_cnt = 0; both_cnt = 0; done_nocrc_cnt = 0;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [63:0] d, input logic last, input logic [5:0] pn, input logic ph);
    int w;
    w = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = last; wr_prefix_num = pn; wr_is_phd = ph;
    @(negedge clk);
    while (!wr_ready && w < 50) begin @(negedge clk); w++; end
    if (!wr_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept_timeout: wr_ready=%0b required 1", wr_ready);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while ((pmw_busy || !wr_ready) && w < 50) begin @(negedge clk); w++; end
    n_cmp++;
    if (pmw_busy || !wr_ready) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%0b ready=%0b required 0/1", pmw_busy, wr_ready);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_data = 64'd0; wr_last = 1'b0;
    wr_prefix_num = 6'd0; wr_is_phd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", wr_ready); end
    n_cmp++; if ({pfd_wr_en, phd_wr_en} !== 2'b00) begin n_bad++; $display("FAIL rst_wren: got %b want 00", {pfd_wr_en, phd_wr_en}); end
    n_cmp++; if ({pmw_done, pmw_err, pmw_busy} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {pmw_done, pmw_err, pmw_busy}); end
    n_cmp++; if (pmw_crc !== 32'd0) begin n_bad++; $display("FAIL rst_crc: got %h want 0", pmw_crc); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %0b want 1", wr_ready); end
    @(posedge clk); #1;
  endtask

  logic [31:0] crc_first;

  // PFD prefix 3, 128 beats of k; later beats carry junk prefix/kind that must be ignored
  task automatic test_pfd_full();
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    clear_log();
    for (int k = 0; k < 128; k++) begin
      send_beat(64'(k), k == 127, (k == 0) ? 6'd3 : 6'(k + 7), (k == 0) ? 1'b0 : 1'(k));
      m = ref_crc_word(m, 64'(k));
    end
    n_cmp++; if (pmw_done !== 1'b0 || pfd_wr_addr !== 13'h1FF) begin n_bad++; $display("FAIL pfd_t1: done=%0b addr=%h want 0/1ff", pmw_done, pfd_wr_addr); end
    @(posedge clk); #1;
    n_cmp++; if ({pmw_done, pfd_wr_en} !== 2'b11 || pfd_wr_addr !== 13'h003) begin n_bad++; $display("FAIL pfd_t2: done/en=%b addr=%h want 11/003", {pmw_done, pfd_wr_en}, pfd_wr_addr); end
    wait_idle();
    crc_first = ~m;
    n_cmp++; if (pfd_a.size() !== 129) begin n_bad++; $display("FAIL pfd_count: got %0d want 129", pfd_a.size()); end
    for (int k = 0; k < 128 && k < pfd_a.size(); k++) begin
      n_cmp++;
      if (pfd_a[k] !== 13'(13'h180 + k) || pfd_d[k] !== 64'(k)) begin
        n_bad++; $display("FAIL pfd_word%0d: addr=%h data=%h want %h/%h", k, pfd_a[k], pfd_d[k], 13'(13'h180 + k), 64'(k));
      end
    end
    if (pfd_a.size() == 129) begin
      n_cmp++;
      if (pfd_a[128] !== 13'h003 || pfd_d[128] !== {32'd0, ~m}) begin
        n_bad++; $display("FAIL pfd_crc_entry: addr=%h data=%h want 003/%h", pfd_a[128], pfd_d[128], {32'd0, ~m});
      end
    end
    n_cmp++; if (pmw_crc !== ~m) begin n_bad++; $display("FAIL pfd_pmw_crc: got %h want %h", pmw_crc, ~m); end
    n_cmp++; if (done_cnt !== 1 || err_cnt !== 0) begin n_bad++; $display("FAIL pfd_pulses: done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    n_cmp++; if (phd_a.size() !== 0 || both_cnt !== 0 || done_nocrc_cnt !== 0) begin n_bad++; $display("FAIL pfd_misc: phd=%0d both=%0d dnc=%0d want 0", phd_a.size(), both_cnt, done_nocrc_cnt); end
  endtask

  // PHD prefix 2, 64 beats -> memory 65..128, CRC at 042, reader recompute
  task automatic test_phd_full();
    logic [31:0] m;
    logic [31:0] rd;
    m = 32'hFFFF_FFFF;
    clear_log();
    for (int k = 0; k < 64; k++) begin
      send_beat(pfd_word(k, 32'h9E37_79B9) ^ 64'hA5A5_0000_0000_5A5A, k == 63, 6'd2, 1'b1);
      m = ref_crc_word(m, pfd_word(k, 32'h9E37_79B9) ^ 64'hA5A5_0000_0000_5A5A);
    end
    wait_idle();
    n_cmp++; if (phd_a.size() !== 64) begin n_bad++; $display("FAIL phd_count: got %0d want 64", phd_a.size()); end
    rd = 32'hFFFF_FFFF;
    for (int k = 0; k < phd_a.size(); k++) begin
      rd = ref_crc_word(rd, phd_d[k]);
      n_cmp++;
      if (phd_a[k] !== 12'(65 + k)) begin n_bad++; $display("FAIL phd_addr%0d: got %0d want %0d", k, phd_a[k], 65 + k); end
    end
    n_cmp++; if (pfd_a.size() !== 1) begin n_bad++; $display("FAIL phd_pfd_count: got %0d want 1", pfd_a.size()); end
    if (pfd_a.size() == 1) begin
      n_cmp++; if (pfd_a[0] !== 13'h042 || pfd_d[0] !== {32'd0, ~m}) begin n_bad++; $display("FAIL phd_crc_entry: addr=%h data=%h want 042/%h", pfd_a[0], pfd_d[0], {32'd0, ~m}); end
      n_cmp++; if (~rd !== pfd_d[0][31:0]) begin n_bad++; $display("FAIL phd_reader_check: recomputed %h stored %h", ~rd, pfd_d[0][31:0]); end
    end
    n_cmp++; if (done_cnt !== 1 || err_cnt !== 0) begin n_bad++; $display("FAIL phd_pulses: done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
  endtask

  // PFD prefix 5, wr_last on beat 10 -> 10 writes, err, no CRC entry
  task automatic test_pfd_short();
    logic [31:0] crc_before;
    crc_before = pmw_crc;
    clear_log();
    for (int k = 0; k <= 10; k++) send_beat(pfd_word(k, 77), k == 10, 6'd5, 1'b0);
    n_cmp++; if (pmw_err !== 1'b1) begin n_bad++; $display("FAIL short_err_t1: got %0b want 1", pmw_err); end
    wait_idle();
    n_cmp++; if (pfd_a.size() !== 10) begin n_bad++; $display("FAIL short_count: got %0d want 10", pfd_a.size()); end
    for (int k = 0; k < pfd_a.size(); k++) begin
      n_cmp++; if (pfd_a[k] !== 13'(13'h280 + k) || pfd_d[k] !== pfd_word(k, 77)) begin n_bad++; $display("FAIL short_word%0d: addr=%h want %h", k, pfd_a[k], 13'(13'h280 + k)); end
      n_cmp++; if (pfd_a[k] === 13'h005) begin n_bad++; $display("FAIL short_crc_written: addr=%h", pfd_a[k]); end
    end
    n_cmp++; if (done_cnt !== 0 || err_cnt !== 1) begin n_bad++; $display("FAIL short_pulses: done=%0d err=%0d want 0/1", done_cnt, err_cnt); end
    n_cmp++; if (pmw_crc !== crc_before) begin n_bad++; $display("FAIL short_pmw_crc: got %h want %h", pmw_crc, crc_before); end
  endtask

  // prefix 0 image of 4 beats: nothing written, single err, back to IDLE
  task automatic test_prefix_zero();
    clear_log();
    for (int k = 0; k < 4; k++) send_beat(64'hDEAD_0000 + 64'(k), k == 3, (k == 0) ? 6'd0 : 6'd9, 1'b0);
    wait_idle();
    n_cmp++; if (pfd_a.size() !== 0 || phd_a.size() !== 0) begin n_bad++; $display("FAIL zero_writes: pfd=%0d phd=%0d want 0/0", pfd_a.size(), phd_a.size()); end
    n_cmp++; if (done_cnt !== 0 || err_cnt !== 1) begin n_bad++; $display("FAIL zero_pulses: done=%0d err=%0d want 0/1", done_cnt, err_cnt); end
  endtask

  // PHD prefix 4 image of 70 beats: 64 written, err, rest drained, no CRC
  task automatic test_phd_long();
    clear_log();
    for (int k = 0; k < 70; k++) begin
      if (k >= 64) begin
        @(negedge clk);
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL long_drain_ready%0d: got %0b want 1", k, wr_ready); end
        @(posedge clk); #1;
      end
      send_beat(64'h1111_0000_0000_0000 | 64'(k), k == 69, 6'd4, 1'b1);
      if (k == 63) begin
        n_cmp++; if (pmw_err !== 1'b1) begin n_bad++; $display("FAIL long_err_t1: got %0b want 1", pmw_err); end
      end
    end
    wait_idle();
    n_cmp++; if (phd_a.size() !== 64) begin n_bad++; $display("FAIL long_count: got %0d want 64", phd_a.size()); end
    if (phd_a.size() == 64) begin
      n_cmp++; if (phd_a[0] !== 12'd195 || phd_a[63] !== 12'd258) begin n_bad++; $display("FAIL long_addr: first=%0d last=%0d want 195/258", phd_a[0], phd_a[63]); end
    end
    n_cmp++; if (pfd_a.size() !== 0) begin n_bad++; $display("FAIL long_crc_written: pfd=%0d want 0", pfd_a.size()); end
    n_cmp++; if (done_cnt !== 0 || err_cnt !== 1) begin n_bad++; $display("FAIL long_pulses: done=%0d err=%0d want 0/1", done_cnt, err_cnt); end
  endtask

  // Gapped repeat of the first PFD load, then reset mid-load and a clean load
  task automatic test_gaps_reset();
    logic [31:0] m;
    clear_log();
    for (int k = 0; k < 128; k++) begin
      send_beat(64'(k), k == 127, 6'd3, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    n_cmp++; if (pmw_crc !== crc_first) begin n_bad++; $display("FAIL gap_crc: got %h want %h", pmw_crc, crc_first); end
    n_cmp++; if (pfd_a.size() !== 129 || done_cnt !== 1) begin n_bad++; $display("FAIL gap_count: pfd=%0d done=%0d want 129/1", pfd_a.size(), done_cnt); end

    for (int k = 0; k < 50; k++) send_beat(64'hFFFF_0000 + 64'(k), 1'b0, 6'd7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (wr_ready !== 1'b0 || pmw_busy !== 1'b0 || pmw_crc !== 32'd0) begin n_bad++; $display("FAIL midrst_state: ready=%0b busy=%0b crc=%h want 0/0/0", wr_ready, pmw_busy, pmw_crc); end
    @(posedge clk); #1; rst = 1'b0;
    clear_log();
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== 0 || err_cnt !== 0 || pfd_a.size() !== 0) begin n_bad++; $display("FAIL midrst_quiet: done=%0d err=%0d pfd=%0d want 0", done_cnt, err_cnt, pfd_a.size()); end

    m = 32'hFFFF_FFFF;
    for (int k = 0; k < 128; k++) begin
      send_beat(64'(k * 3 + 1), k == 127, 6'd9, 1'b0);
      m = ref_crc_word(m, 64'(k * 3 + 1));
    end
    wait_idle();
    n_cmp++; if (pmw_crc !== ~m) begin n_bad++; $display("FAIL post_rst_crc: got %h want %h", pmw_crc, ~m); end
    if (pfd_a.size() == 129) begin
      n_cmp++; if (pfd_a[0] !== 13'h480 || pfd_a[128] !== 13'h009) begin n_bad++; $display("FAIL post_rst_addr: first=%h crc=%h want 480/009", pfd_a[0], pfd_a[128]); end
    end else begin
      n_cmp++; n_bad++; $display("FAIL post_rst_count: got %0d want 129", pfd_a.size());
    end
    n_cmp++; if (done_cnt !== 1 || err_cnt !== 0) begin n_bad++; $display("FAIL post_rst_pulses: done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_pfd_full();
    test_phd_full();
    test_pfd_short();
    test_prefix_zero();
    test_phd_long();
    test_gaps_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cr_prefix_load_pmw.md
Name: cr_prefix_load_pmw

Overview:
- Write-side counterpart of the prefix-attach memory-check reader: loads one prefix image (PFD or PHD) from a 64-bit beat stream into the PFD/PHD memories.
- Runs the XP10 CRC32 over every stored word and writes the complemented result into the CRC table held in PFD memory. The read/check path then recomputes the CRC and compares it against this entry.
- Sits between the prefix-load register/DMA path and the PFD/PHD memory write ports.

Parameters:
- N_PFD_WORDS, 128, exact beat count of a PFD image (max 128).
- N_PHD_WORDS, 64, exact beat count of a PHD image (max 65).
- PHD_STRIDE, 65, PHD memory entries reserved per prefix.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- wr_valid  input  1  beat valid
- wr_ready  output  1  beat accept
- wr_data  input  64  payload word
- wr_last  input  1  final beat of image
- wr_prefix_num  input  6  prefix index 1..63; sampled on first beat
- wr_is_phd  input  1  0=PFD image, 1=PHD image; sampled on first beat
- pfd_wr_en  output  1  PFD memory write strobe
- pfd_wr_addr  output  13  PFD memory address
- pfd_wr_data  output  64  PFD memory write data
- phd_wr_en  output  1  PHD memory write strobe
- phd_wr_addr  output  12  PHD memory address
- phd_wr_data  output  64  PHD memory write data
- pmw_busy  output  1  transfer in progress (state != IDLE)
- pmw_done  output  1  one-cycle pulse: image and CRC entry written
- pmw_err  output  1  one-cycle pulse: image rejected, no CRC written
- pmw_crc  output  32  last CRC entry written (already complemented)

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset: state IDLE, wr_ready=0 during reset, all write enables 0, pmw_done=pmw_err=0, pmw_crc=0, CRC accumulator=32'hFFFF_FFFF, beat counter=0.
- A beat transfers when wr_valid & wr_ready. wr_ready=1 in IDLE, DATA and DRAIN; 0 in CRC_WR and FIN.
- IDLE, beat accepted:
  - Latch prefix_num and is_phd.
  - If prefix_num==0: pmw_err pulses next cycle. Go to DRAIN, or stay in IDLE if wr_last was set on that beat.
  - Otherwise treat the beat as beat 0 of DATA.
- DATA, beat k accepted at cycle t: registered write at t+1.
  - PFD image: pfd_wr_addr={prefix_num,k[6:0]}.
  - PHD image: phd_wr_addr=(prefix_num-1)*PHD_STRIDE+k, truncated to 12 bits.
  - Write data is wr_data. At t+1 the accumulator holds crc32_xp(wr_data, acc, 64), using the XP10 polynomial, 64 bits per beat, same function as the reader.
- Beat-count checks, with N = N_PHD_WORDS or N_PFD_WORDS:
  - wr_last on beat k==N-1: go to CRC_WR.
  - wr_last on beat k<N-1: no further writes, pmw_err at t+1, go to IDLE. Words already written stay in memory; their CRC entry is left stale.
  - Beat k==N-1 without wr_last: that word is still written, pmw_err at t+1, go to DRAIN.
- DRAIN: accept and discard beats with no writes and no CRC update. Leave on an accepted wr_last, going to IDLE.
- CRC_WR (one cycle, t+1 after the last beat):
  - At t+2, pfd_wr_en=1, pfd_wr_addr={6'd0,is_phd,prefix_num}, pfd_wr_data={32'd0,~acc}.
  - pmw_crc updates to ~acc.
  - Go to FIN.
- FIN: pmw_done=1 for one cycle (t+2, coincident with the CRC write). Reset acc to 32'hFFFF_FFFF and the counter to 0. Go to IDLE.
- pfd_wr_en and phd_wr_en are never asserted in the same cycle. The CRC-table write never overlaps a data write.
- The accumulator and counter are also reinitialised on every entry to IDLE via the error paths.
- Reset asserted mid-transfer aborts the transfer: no done/err pulse, no CRC write; the partial image is left in memory.
- wr_prefix_num and wr_is_phd are ignored on every beat except the first.

Test Plan:
- PFD, prefix 3, 128 beats with wr_data=k -> pfd writes at 13'h180+k. After the last beat, CRC write at 13'h003 with data ~crc32 over the 128 words; pmw_done once; pmw_err never.
- PHD, prefix 2, 64 beats -> phd writes at 65..128. CRC write at 13'h042; reader-model recompute of the CRC matches the stored entry.
- PFD, prefix 5, wr_last on beat 10 -> 10 data writes, pmw_err 1 cycle, no write to 13'h005, pmw_done never.
- prefix_num 0, 4 beats -> zero writes, pmw_err once, module back in IDLE and accepting the next image.
- PHD image of 70 beats -> 64 data writes, pmw_err after beat 63, beats 64..69 drained with wr_ready=1, no CRC write.
- Random wr_valid gaps on a PFD load, plus rst pulsed at beat 50 of a second load -> first CRC identical to the gap-free run; after reset no done/err pulses, acc=FFFF_FFFF, next load correct.
